// File: rtl/classificador_face_pkg.sv
// ============================================================================
// Module   : classificador_face_pkg
// Purpose  : Colour codes, FSM encodings and default thresholds shared by the
//            face classifier and its per-pixel colour classifier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package classificador_face_pkg;

  localparam logic [2:0] BRANCO       = 3'd0;
  localparam logic [2:0] AMARELO      = 3'd1;
  localparam logic [2:0] VERMELHO     = 3'd2;
  localparam logic [2:0] LARANJA      = 3'd3;
  localparam logic [2:0] AZUL         = 3'd4;
  localparam logic [2:0] VERDE        = 3'd5;
  localparam logic [2:0] DESCONHECIDO = 3'd7;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ENDERECO = 2'd1,
    CAPTURA  = 2'd2,
    PRONTO   = 2'd3
  } estado_t;

  localparam int unsigned T_DARK_DEF   = 12;
  localparam int unsigned T_WHITE_DEF  = 40;
  localparam int unsigned D_YEL_DEF    = 8;
  localparam int unsigned T_ORANGE_DEF = 20;

endpackage

`default_nettype wire

// File: rtl/classificador_cor.sv
// ============================================================================
// Module   : classificador_cor
// Purpose  : Combinational RGB565 pixel to Rubik's colour code classifier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module classificador_cor
  import classificador_face_pkg::*;
#(
  parameter int unsigned T_DARK   = T_DARK_DEF,
  parameter int unsigned T_WHITE  = T_WHITE_DEF,
  parameter int unsigned D_YEL    = D_YEL_DEF,
  parameter int unsigned T_ORANGE = T_ORANGE_DEF
) (
  input  logic [15:0] pixel,
  output logic [2:0]  code
);

  localparam logic [5:0] C_T_DARK   = 6'(T_DARK);
  localparam logic [5:0] C_T_WHITE  = 6'(T_WHITE);
  localparam logic [6:0] C_D_YEL    = 7'(D_YEL);
  localparam logic [5:0] C_T_ORANGE = 6'(T_ORANGE);

  logic [5:0]        w_r, w_g, w_b;
  logic [5:0]        w_max, w_min;
  logic signed [6:0] w_diff;
  logic [6:0]        w_abs;

  // 5-bit red/blue are scaled to the 6-bit green range
  assign w_r = {pixel[15:11], 1'b0};
  assign w_g = pixel[10:5];
  assign w_b = {pixel[4:0], 1'b0};

  always_comb begin
    w_max = w_r;
    w_min = w_r;
    if (w_g > w_max) w_max = w_g;
    if (w_b > w_max) w_max = w_b;
    if (w_g < w_min) w_min = w_g;
    if (w_b < w_min) w_min = w_b;
  end

  assign w_diff = $signed({1'b0, w_r}) - $signed({1'b0, w_g});
  assign w_abs  = w_diff[6] ? $unsigned(-w_diff) : $unsigned(w_diff);

  // First matching rule wins
  always_comb begin
    code = VERMELHO;
    if (w_max < C_T_DARK)                code = DESCONHECIDO;
    else if (w_min >= C_T_WHITE)         code = BRANCO;
    else if (w_b >= w_r && w_b >= w_g)   code = AZUL;
    else if (w_abs <= C_D_YEL)           code = AMARELO;
    else if (w_g > w_r)                  code = VERDE;
    else if (w_g >= C_T_ORANGE)          code = LARANJA;
    else                                 code = VERMELHO;
  end

endmodule

`default_nettype wire

// File: rtl/classificador_face.sv
// ============================================================================
// Module   : classificador_face
// Purpose  : Scans the 3x3 sample memory, classifies each pixel and packs the
//            nine colour codes into a 27-bit face word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module classificador_face
  import classificador_face_pkg::*;
#(
  parameter int unsigned T_DARK   = T_DARK_DEF,
  parameter int unsigned T_WHITE  = T_WHITE_DEF,
  parameter int unsigned D_YEL    = D_YEL_DEF,
  parameter int unsigned T_ORANGE = T_ORANGE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inicia,
  input  logic [15:0] pixel,
  output logic [1:0]  addr_line,
  output logic [1:0]  addr_column,
  output logic [26:0] face,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  n_desconhecidos,
  output logic [1:0]  db_estado
);

  estado_t     r_estado, w_prox;
  logic [1:0]  r_line, r_column;
  logic [26:0] r_face;
  logic [3:0]  r_n;
  logic [2:0]  w_code;
  logic [3:0]  w_k;
  logic [4:0]  w_base;
  logic        w_limpa, w_captura;

  classificador_cor #(
    .T_DARK   (T_DARK),
    .T_WHITE  (T_WHITE),
    .D_YEL    (D_YEL),
    .T_ORANGE (T_ORANGE)
  ) u_cor (
    .pixel (pixel),
    .code  (w_code)
  );

  assign w_k    = 4'(r_line) * 4'd3 + 4'(r_column);
  assign w_base = 5'(w_k) * 5'd3;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= OCIOSO;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox    = r_estado;
    w_limpa   = 1'b0;
    w_captura = 1'b0;
    case (r_estado)
      OCIOSO, PRONTO: begin
        if (inicia) begin
          w_limpa = 1'b1;
          w_prox  = ENDERECO;
        end
      end
      ENDERECO: w_prox = CAPTURA;
      CAPTURA: begin
        w_captura = 1'b1;
        w_prox    = (w_k == 4'd8) ? PRONTO : ENDERECO;
      end
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_line   <= 2'd0;
      r_column <= 2'd0;
      r_face   <= '0;
      r_n      <= 4'd0;
    end else if (w_limpa) begin
      r_line   <= 2'd0;
      r_column <= 2'd0;
      r_face   <= '0;
      r_n      <= 4'd0;
    end else if (w_captura) begin
      r_face[w_base +: 3] <= w_code;
      if (w_code == DESCONHECIDO) r_n <= r_n + 4'd1;
      // Last pixel leaves the address parked at (2,2)
      if (w_k != 4'd8) begin
        if (r_column == 2'd2) begin
          r_column <= 2'd0;
          r_line   <= r_line + 2'd1;
        end else begin
          r_column <= r_column + 2'd1;
        end
      end
    end
  end

  assign addr_line       = r_line;
  assign addr_column     = r_column;
  assign face            = r_face;
  assign n_desconhecidos = r_n;
  assign pronto          = (r_estado == PRONTO);
  assign erro            = pronto && (r_n != 4'd0);
  assign db_estado       = r_estado;

endmodule

`default_nettype wire
